// File: rtl/alu_op_issuer.sv
// ALU operation issuer: decodes ALUOp/Funct3/Funct7 into an ALU opcode and buffers it in a 2-entry FIFO.
// Optional saturating illegal-decode counter enabled by defining ALU_ILLEGAL_CNT_EN.
module alu_op_issuer #(
   parameter int OPCODE_LENGTH = 4,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               ALUOp,
   input  logic [2:0]               Funct3,
   input  logic [6:0]               Funct7,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OPCODE_LENGTH-1:0] Operation,
`ifdef ALU_ILLEGAL_CNT_EN
   output logic [CNT_WIDTH-1:0]     illegal_cnt,
`endif
   output logic                     illegal
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_XOR   = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SLTI  = 4'b0011;
   localparam logic [3:0] OP_OR    = 4'b0101;
   localparam logic [3:0] OP_SLL   = 4'b0110;
   localparam logic [3:0] OP_SRA   = 4'b0111;
   localparam logic [3:0] OP_EQUAL = 4'b1000;
   localparam logic [3:0] OP_SUB   = 4'b1010;
   localparam logic [3:0] OP_ADDI  = 4'b1011;
   localparam logic [3:0] OP_SLT   = 4'b1100;
   localparam logic [3:0] OP_SRL   = 4'b1110;
   localparam logic [3:0] OP_ILL   = 4'b1111;

   logic [3:0] w_dec_op4;
   logic       w_dec_ill;
   logic       w_accept;
   logic       w_pop;

   logic [1:0]               r_count;
   logic                     r_wr_ptr;
   logic                     r_rd_ptr;
   logic [OPCODE_LENGTH-1:0] r_op_mem  [2];
   logic                     r_ill_mem [2];

   always_comb begin
      // NOTE: default assignment first so every path drives w_dec_op4 and no latch is inferred.
      w_dec_op4 = OP_ILL;
      case (ALUOp)
         2'b00: w_dec_op4 = OP_ADD;
         2'b01: if (Funct3 == 3'b000) w_dec_op4 = OP_EQUAL;
         2'b10: begin
            case ({Funct3, Funct7})
               {3'b000, 7'b0000000}: w_dec_op4 = OP_ADD;
               {3'b000, 7'b0100000}: w_dec_op4 = OP_SUB;
               {3'b111, 7'b0000000}: w_dec_op4 = OP_AND;
               {3'b110, 7'b0000000}: w_dec_op4 = OP_OR;
               {3'b100, 7'b0000000}: w_dec_op4 = OP_XOR;
               {3'b010, 7'b0000000}: w_dec_op4 = OP_SLT;
               {3'b001, 7'b0000000}: w_dec_op4 = OP_SLL;
               {3'b101, 7'b0000000}: w_dec_op4 = OP_SRL;
               {3'b101, 7'b0100000}: w_dec_op4 = OP_SRA;
               default:              w_dec_op4 = OP_ILL;
            endcase
         end
         default: begin
            case (Funct3)
               3'b000: w_dec_op4 = OP_ADDI;
               3'b010: w_dec_op4 = OP_SLTI;
               3'b111: w_dec_op4 = OP_AND;
               3'b110: w_dec_op4 = OP_OR;
               3'b100: w_dec_op4 = OP_XOR;
               3'b001: if (Funct7 == 7'b0000000) w_dec_op4 = OP_SLL;
               3'b101: begin
                  if (Funct7 == 7'b0000000)      w_dec_op4 = OP_SRL;
                  else if (Funct7 == 7'b0100000) w_dec_op4 = OP_SRA;
               end
               default: w_dec_op4 = OP_ILL;
            endcase
         end
      endcase
   end

   // No legal encoding maps to 1111, so the illegal flag falls out of the opcode.
   assign w_dec_ill = (w_dec_op4 == OP_ILL);

   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign w_accept  = in_valid && in_ready && !flush;
   assign w_pop     = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments for all sequential state avoid evaluation-order races.
      if (!rst_n) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else if (flush) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
      end else begin
         if (w_accept) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)    r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + 2'(w_accept) - 2'(w_pop);
      end
   end

   // NOTE: storage is not reset; outputs are forced to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op_mem[r_wr_ptr]  <= OPCODE_LENGTH'(w_dec_op4);
         r_ill_mem[r_wr_ptr] <= w_dec_ill;
      end
   end

   assign Operation = out_valid ? r_op_mem[r_rd_ptr] : '0;
   assign illegal   = out_valid ? r_ill_mem[r_rd_ptr] : 1'b0;

`ifdef ALU_ILLEGAL_CNT_EN
   logic [CNT_WIDTH-1:0] r_illegal_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal_cnt <= '0;
      end else if (w_accept && w_dec_ill && (r_illegal_cnt != '1)) begin
         r_illegal_cnt <= r_illegal_cnt + 1'b1;
      end
   end

   assign illegal_cnt = r_illegal_cnt;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Self-checking bench for alu_op_issuer: directed steps plus a random burst, scoreboard queue of expected heads.
// Counter checks are active when ALU_ILLEGAL_CNT_EN is defined (counter width 2 to reach saturation).
module tb_alu_op_issuer;

   typedef struct {
      logic [1:0] a;
      logic [2:0] f3;
      logic       f3_care;
      logic [6:0] f7;
      logic       f7_care;
      logic [3:0] op;
   } rule_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [1:0] ALUOp = 2'b00;
   logic [2:0] Funct3 = 3'b000;
   logic [6:0] Funct7 = 7'b0000000;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] Operation;
   logic       illegal;
`ifdef ALU_ILLEGAL_CNT_EN
   logic [1:0] illegal_cnt;
`endif

   int         n_checks = 0;
   int         n_fail   = 0;
   int         m_count  = 0;
   int         m_cnt    = 0;
   logic [4:0] sb[$];
   rule_t      rules[$];

   alu_op_issuer #(.OPCODE_LENGTH(4), .CNT_WIDTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .ALUOp      (ALUOp),
      .Funct3     (Funct3),
      .Funct7     (Funct7),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .Operation  (Operation),
`ifdef ALU_ILLEGAL_CNT_EN
      .illegal_cnt(illegal_cnt),
`endif
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   task automatic add_rule(input logic [1:0] a, input logic [2:0] f3, input logic f3c,
                           input logic [6:0] f7, input logic f7c, input logic [3:0] op);
      rule_t r;
      r.a = a; r.f3 = f3; r.f3_care = f3c; r.f7 = f7; r.f7_care = f7c; r.op = op;
      rules.push_back(r);
   endtask

   // Expected {illegal, opcode} from the rule table; no match means illegal 1111.
   function automatic logic [4:0] ref_decode(input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7);
      foreach (rules[i]) begin
         if (rules[i].a == a && (!rules[i].f3_care || rules[i].f3 == f3) &&
             (!rules[i].f7_care || rules[i].f7 == f7))
            return {1'b0, rules[i].op};
      end
      return 5'b1_1111;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7,
                        input logic rdy, input logic fl);
      in_valid = v; ALUOp = a; Funct3 = f3; Funct7 = f7; out_ready = rdy; flush = fl;
   endtask

   // Called at a falling edge: compare outputs against the model, then advance one clock.
   task automatic tick();
      logic acc, pop;
      check("in_ready", 16'(in_ready), 16'(m_count < 2));
      check("out_valid", 16'(out_valid), 16'(m_count != 0));
      if (m_count != 0) begin
         check("Operation", 16'(Operation), 16'(sb[0][3:0]));
         check("illegal", 16'(illegal), 16'(sb[0][4]));
      end else begin
         check("Operation_empty", 16'(Operation), 16'h0);
         check("illegal_empty", 16'(illegal), 16'h0);
      end
`ifdef ALU_ILLEGAL_CNT_EN
      check("illegal_cnt", 16'(illegal_cnt), 16'(m_cnt));
`endif
      acc = in_valid && (m_count < 2) && !flush;
      pop = (m_count != 0) && out_ready && !flush;
      if (flush) begin
         sb.delete();
         m_count = 0;
      end else begin
         if (pop) begin
            void'(sb.pop_front());
            m_count--;
         end
         if (acc) begin
            sb.push_back(ref_decode(ALUOp, Funct3, Funct7));
            m_count++;
         end
      end
      if (acc && ref_decode(ALUOp, Funct3, Funct7)[4] && m_cnt < 3) m_cnt++;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      add_rule(2'b00, 3'b000, 1'b0, 7'h00, 1'b0, 4'b0010);
      add_rule(2'b01, 3'b000, 1'b1, 7'h00, 1'b0, 4'b1000);
      add_rule(2'b10, 3'b000, 1'b1, 7'h00, 1'b1, 4'b0010);
      add_rule(2'b10, 3'b000, 1'b1, 7'h20, 1'b1, 4'b1010);
      add_rule(2'b10, 3'b111, 1'b1, 7'h00, 1'b1, 4'b0000);
      add_rule(2'b10, 3'b110, 1'b1, 7'h00, 1'b1, 4'b0101);
      add_rule(2'b10, 3'b100, 1'b1, 7'h00, 1'b1, 4'b0001);
      add_rule(2'b10, 3'b010, 1'b1, 7'h00, 1'b1, 4'b1100);
      add_rule(2'b10, 3'b001, 1'b1, 7'h00, 1'b1, 4'b0110);
      add_rule(2'b10, 3'b101, 1'b1, 7'h00, 1'b1, 4'b1110);
      add_rule(2'b10, 3'b101, 1'b1, 7'h20, 1'b1, 4'b0111);
      add_rule(2'b11, 3'b000, 1'b1, 7'h00, 1'b0, 4'b1011);
      add_rule(2'b11, 3'b010, 1'b1, 7'h00, 1'b0, 4'b0011);
      add_rule(2'b11, 3'b111, 1'b1, 7'h00, 1'b0, 4'b0000);
      add_rule(2'b11, 3'b110, 1'b1, 7'h00, 1'b0, 4'b0101);
      add_rule(2'b11, 3'b100, 1'b1, 7'h00, 1'b0, 4'b0001);
      add_rule(2'b11, 3'b001, 1'b1, 7'h00, 1'b1, 4'b0110);
      add_rule(2'b11, 3'b101, 1'b1, 7'h00, 1'b1, 4'b1110);
      add_rule(2'b11, 3'b101, 1'b1, 7'h20, 1'b1, 4'b0111);

      #12 rst_n = 1'b1;
      @(negedge clk);
      tick();

      // Single R-type SUB with out_ready high: one cycle latency, then empty.
      drive(1'b1, 2'b10, 3'b000, 7'h20, 1'b1, 1'b0);
      tick();
      drive(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
      tick();
      tick();

      // Fill with out_ready low, hold, then drain in order.
      drive(1'b1, 2'b11, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      drive(1'b1, 2'b01, 3'b000, 7'h00, 1'b0, 1'b0);
      tick();
      drive(1'b1, 2'b10, 3'b111, 7'h00, 1'b0, 1'b0);
      tick();
      tick();
      drive(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
      tick();
      tick();
      tick();

      // Four illegal accepts drive the narrow counter into saturation.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'b01, 3'b001, 7'h00, 1'b1, 1'b0);
         tick();
      end
      drive(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
      tick();
      tick();

      // Flush while full with in_valid and out_ready high.
      drive(1'b1, 2'b10, 3'b001, 7'h00, 1'b0, 1'b0);
      tick();
      drive(1'b1, 2'b11, 3'b101, 7'h20, 1'b0, 1'b0);
      tick();
      drive(1'b1, 2'b01, 3'b011, 7'h00, 1'b1, 1'b1);
      tick();
      drive(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
      tick();

      // Asynchronous reset between edges with two entries held.
      drive(1'b1, 2'b00, 3'b101, 7'h55, 1'b0, 1'b0);
      tick();
      drive(1'b1, 2'b11, 3'b010, 7'h7f, 1'b0, 1'b0);
      tick();
      drive(1'b0, 2'b00, 3'b000, 7'h00, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 16'(out_valid), 16'h0);
      check("rst_Operation", 16'(Operation), 16'h0);
      check("rst_illegal", 16'(illegal), 16'h0);
      check("rst_in_ready", 16'(in_ready), 16'h1);
      sb.delete();
      m_count = 0;
      m_cnt = 0;
      #1 rst_n = 1'b1;
      @(negedge clk);
      tick();

      // Every decode rule, streamed with a pop each cycle, plus illegal variants.
      foreach (rules[i]) begin
         drive(1'b1, rules[i].a, rules[i].f3, rules[i].f7, 1'b1, 1'b0);
         tick();
      end
      drive(1'b1, 2'b10, 3'b011, 7'h00, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'b11, 3'b001, 7'h20, 1'b1, 1'b0);
      tick();
      drive(1'b1, 2'b10, 3'b111, 7'h20, 1'b1, 1'b0);
      tick();

      // Random burst exercising full/empty transitions and occasional flush.
      for (int i = 0; i < 200; i++) begin
         logic [6:0] f7;
         case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         drive(1'($urandom), 2'($urandom), 3'($urandom), f7, 1'($urandom),
               ($urandom_range(0, 9) == 0));
         tick();
      end
      drive(1'b0, 2'b00, 3'b000, 7'h00, 1'b1, 1'b0);
      tick();
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_op_issuer.md
ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 Parameter: OPCODE_LENGTH, default 4, width of the Operation code driven to the ALU.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the illegal-decode counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous discard of all buffered entries.
REQ-006 in_valid  input  1  upstream presents a decode request.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 ALUOp  input  2  instruction class: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
REQ-009 Funct3  input  3  instruction funct3 field.
REQ-010 Funct7  input  7  instruction funct7 field.
REQ-011 out_valid  output  1  Operation/illegal at head are valid.
REQ-012 out_ready  input  1  ALU stage consumes head entry.
REQ-013 Operation  output  OPCODE_LENGTH  ALU operation code of head entry.
REQ-014 illegal  output  1  head entry is an unsupported encoding.
REQ-015 illegal_cnt  output  CNT_WIDTH  count of illegal decodes (present only per REQ-035).

Function
REQ-016 Accept = in_valid && in_ready && !flush; pop = out_valid && out_ready && !flush.
REQ-017 Decode ALUOp 00 -> 0010 (ADD), any Funct3/Funct7.
REQ-018 Decode ALUOp 01: Funct3 000 -> 1000 (EQUAL); other Funct3 illegal.
REQ-019 Decode ALUOp 10 (Funct3/Funct7): 000/0000000 0010 ADD; 000/0100000 1010 SUB; 111/0 0000 AND; 110/0 0101 OR; 100/0 0001 XOR; 010/0 1100 SLT; 001/0 0110 SLL; 101/0 1110 SRL; 101/0100000 0111 SRA.
REQ-020 Decode ALUOp 11 (Funct3): 000 1011 ADDI; 010 0011 SLTI; 111 0000 ANDI; 110 0101 ORI; 100 0001 XORI; 001 with Funct7 0 0110 SLLI; 101 with Funct7 0 1110 SRLI; 101 with Funct7 0100000 0111 SRAI.
REQ-021 Any combination not listed in REQ-017..020 is illegal: stored Operation 1111, illegal 1.
REQ-022 Decoded entries are stored in a 2-entry FIFO; output order equals accept order.
REQ-023 Latency: entry accepted in cycle N into an empty FIFO appears with out_valid=1 in cycle N+1.
REQ-024 in_ready = 1 when fewer than 2 entries are held, else 0; no combinational path from out_ready to in_ready.
REQ-025 Accept and pop in the same cycle with 1 entry held: occupancy stays 1, new entry becomes head next cycle.
REQ-026 Full (2 entries): in_ready 0; a pop frees one slot, in_ready 1 the following cycle.
REQ-027 Empty: out_valid 0, Operation 0000, illegal 0; out_ready ignored.
REQ-028 Operation and illegal hold stable while out_valid=1 and out_ready=0.
REQ-029 flush: occupancy 0 next cycle; same-cycle input not accepted; same-cycle out_ready not a pop; flush has priority over all.
REQ-030 FIFO pointers wrap modulo 2.

Reset
REQ-031 rst_n low asynchronously clears occupancy and pointers; out_valid 0, Operation 0000, illegal 0, in_ready 1, illegal_cnt 0.
REQ-032 Reset mid-operation discards all held entries; no entry is delivered after rst_n deasserts until a new accept.
REQ-033 Release of rst_n is sampled on clk; first accept possible on first rising edge with rst_n high.

Configuration
REQ-034 Macro ALU_ILLEGAL_CNT_EN controls the illegal-decode counter.
REQ-035 Defined: illegal_cnt port exists; increments by 1 on each accept decoding illegal; saturates at all-ones; flush does not clear it; only rst_n clears it.
REQ-036 Not defined: illegal_cnt port and counter logic are absent; all other behaviour identical.

Verification
REQ-037 Reset then accept ALUOp 10, Funct3 000, Funct7 0100000, out_ready 1 -> next cycle out_valid 1, Operation 1010, illegal 0; following cycle out_valid 0.
REQ-038 out_ready 0, accept ALUOp 11/Funct3 000 then ALUOp 01/Funct3 000 -> in_ready 0; release out_ready -> Operation 1011 then 1000 on consecutive cycles.
REQ-039 Accept ALUOp 01, Funct3 001 -> Operation 1111, illegal 1; with ALU_ILLEGAL_CNT_EN illegal_cnt 0 -> 1.
REQ-040 FIFO full, assert flush with in_valid 1 and out_ready 1 -> next cycle out_valid 0, in_ready 1, no entry delivered.
REQ-041 With ALU_ILLEGAL_CNT_EN, CNT_WIDTH 2, four illegal accepts -> illegal_cnt 1,2,3,3.
REQ-042 Two entries held, pulse rst_n low between edges -> out_valid 0 and Operation 0000 immediately, in_ready 1.
